// File: rtl/result_display_driver.sv
// result_display_driver: shows an 8-bit result (digits 1:0) and a load count (digits 3:2) on a
// multiplexed common-anode 7-segment display; define GHOST_BLANK_EN to blank the start of each slot.
module result_display_driver #(
    parameter int REFRESH_DIV  = 100_000,
    parameter int BLANK_CYCLES = 1_000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] result_in,
    input  logic       load,
    output logic [6:0] seg,
    output logic       dp,
    output logic [3:0] an
);
    localparam int TW = $clog2(REFRESH_DIV);
    localparam logic [TW-1:0] TICK_MAX = TW'(REFRESH_DIV - 1);

    if (REFRESH_DIV < 4 || BLANK_CYCLES >= REFRESH_DIV) begin : g_bad_cfg
        $error("result_display_driver: need REFRESH_DIV >= 4 and BLANK_CYCLES < REFRESH_DIV");
    end

    logic [TW-1:0] tick_q, tick_d;
    logic [1:0]    dig_q, dig_d;
    logic [7:0]    val_q, val_d, cnt_q, cnt_d;
    logic [6:0]    seg_q, seg_d, glyph;
    logic [3:0]    an_q, an_d, nib;
    logic          dp_q, dp_d, blank;

    always_comb begin
        tick_d = (tick_q == TICK_MAX) ? '0 : tick_q + 1'b1;
        dig_d  = (tick_q == TICK_MAX) ? dig_q + 2'd1 : dig_q;
        val_d  = load ? result_in : val_q;
        cnt_d  = load ? cnt_q + 8'd1 : cnt_q;
        nib    = dig_q[1] ? (dig_q[0] ? cnt_q[7:4] : cnt_q[3:0])
                          : (dig_q[0] ? val_q[7:4] : val_q[3:0]);
`ifdef GHOST_BLANK_EN
        blank  = tick_q < TW'(BLANK_CYCLES);
`else
        blank  = 1'b0;
`endif
        glyph  = 7'b1111111;
        case (nib)
            4'h0: glyph = 7'b1000000;
            4'h1: glyph = 7'b1111001;
            4'h2: glyph = 7'b0100100;
            4'h3: glyph = 7'b0110000;
            4'h4: glyph = 7'b0011001;
            4'h5: glyph = 7'b0010010;
            4'h6: glyph = 7'b0000010;
            4'h7: glyph = 7'b1111000;
            4'h8: glyph = 7'b0000000;
            4'h9: glyph = 7'b0010000;
            4'hA: glyph = 7'b0001000;
            4'hB: glyph = 7'b0000011;
            4'hC: glyph = 7'b1000110;
            4'hD: glyph = 7'b0100001;
            4'hE: glyph = 7'b0000110;
            4'hF: glyph = 7'b0001110;
            default: glyph = 7'b1111111;
        endcase
        // outputs are built from the current state, so they trail it by exactly one cycle
        an_d   = blank ? 4'b1111 : ~(4'b0001 << dig_q);
        seg_d  = blank ? 7'b1111111 : glyph;
        dp_d   = blank || (dig_q != 2'd2);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            tick_q <= '0;
            dig_q  <= '0;
            val_q  <= '0;
            cnt_q  <= '0;
            an_q   <= 4'b1111;
            seg_q  <= 7'b1111111;
            dp_q   <= 1'b1;
        end else begin
            tick_q <= tick_d;
            dig_q  <= dig_d;
            val_q  <= val_d;
            cnt_q  <= cnt_d;
            an_q   <= an_d;
            seg_q  <= seg_d;
            dp_q   <= dp_d;
        end
    end

    assign seg = seg_q;
    assign dp  = dp_q;
    assign an  = an_q;
endmodule

// File: tb/tb_result_display_driver.sv
// tb_result_display_driver: directed stimulus with a cycle-by-cycle reference model of the display.
module tb_result_display_driver;
    localparam int DIV = 8;
`ifdef GHOST_BLANK_EN
    localparam int BL = 2;
`else
    localparam int BL = 0;
`endif

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       load = 1'b0;
    logic [7:0] result_in = 8'h00;
    logic [6:0] seg;
    logic       dp;
    logic [3:0] an;

    int checks = 0;
    int errors = 0;

    result_display_driver #(.REFRESH_DIV(DIV), .BLANK_CYCLES(2)) dut (
        .clk(clk), .rst(rst), .result_in(result_in), .load(load),
        .seg(seg), .dp(dp), .an(an)
    );

    always #5 clk = ~clk;

    logic [6:0] hex [16] = '{7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
                             7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
                             7'b0000000, 7'b0010000, 7'b0001000, 7'b0000011,
                             7'b1000110, 7'b0100001, 7'b0000110, 7'b0001110};

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
        end
    endtask

    // Reference model: n counts non-reset edges since reset; the outputs after edge n describe
    // scan position n (slot n%DIV of digit (n/DIV)%4) using the values held before that edge.
    int  m_n = 0, m_val = 0, m_cnt = 0, slot, d, nib;
    bit  started = 0;
    logic [3:0] e_an;
    logic [6:0] e_seg;
    logic       e_dp;
    always @(posedge clk) begin
        if (rst) begin
            started = 1;
            m_n = 0; m_val = 0; m_cnt = 0;
            e_an = 4'hF; e_seg = 7'h7F; e_dp = 1'b1;
        end else begin
            slot = m_n % DIV;
            d    = (m_n / DIV) % 4;
            nib  = d == 0 ? m_val % 16 : d == 1 ? m_val / 16 : d == 2 ? m_cnt % 16 : m_cnt / 16;
            if (slot < BL) begin
                e_an = 4'hF; e_seg = 7'h7F; e_dp = 1'b1;
            end else begin
                e_an = ~(4'b0001 << d); e_seg = hex[nib]; e_dp = (d != 2);
            end
            m_n++;
            if (load) begin
                m_val = result_in;
                m_cnt = (m_cnt + 1) % 256;
            end
        end
        #1;
        if (started) begin
            chk("model_an", an, e_an);
            chk("model_seg", seg, e_seg);
            chk("model_dp", dp, e_dp);
            chk("an_onehot", int'($countones(~an) <= 1), 1);
        end
    end

    task automatic step();
        @(posedge clk);
        #2;
    endtask

    task automatic wait_an(input logic [3:0] t);
        bit ok = 0;
        for (int i = 0; i < 40 && !ok; i++) begin
            if (an == t) ok = 1;
            else step();
        end
        if (!ok) chk("wait_an_timeout", an, t);
    endtask

    task automatic pulse(input logic [7:0] v);
        load = 1'b1; result_in = v;
        step();
        load = 1'b0;
    endtask

    initial begin
        int act [4];
        // reset for 3 cycles
        repeat (3) step();
        rst = 1'b0;
        chk("rst_an", an, 4'hF);
        chk("rst_seg", seg, 7'h7F);
        chk("rst_dp", dp, 1);
        for (int i = 0; i < BL; i++) begin
            step();
            chk("rst_blank_an", an, 4'hF);
        end
        step();
        chk("first_an", an, 4'b1110);
        chk("first_seg", seg, 7'b1000000);

        // load 0xA5 once and look at every digit
        wait_an(4'b0111);
        pulse(8'hA5);
        step();
        wait_an(4'b1110);
        chk("a5_dig0", seg, 7'b0010010);
        wait_an(4'b1101);
        chk("a5_dig1", seg, 7'b0001000);
        wait_an(4'b1011);
        chk("a5_dig2", seg, 7'b1111001);
        chk("a5_dig2_dp", dp, 0);
        wait_an(4'b0111);
        chk("a5_dig3", seg, 7'b1000000);
        chk("a5_dig3_dp", dp, 1);

        // load latency while digit 0 is active
        wait_an(4'b1110);
        pulse(8'h3F);
        chk("lat_old", seg, 7'b0010010);
        step();
        chk("lat_an", an, 4'b1110);
        chk("lat_new", seg, 7'b0001110);

        // 256 back-to-back loads wrap the count to zero
        rst = 1'b1;
        step();
        rst = 1'b0;
        load = 1'b1;
        for (int i = 0; i < 256; i++) begin
            result_in = 8'(i);
            step();
        end
        load = 1'b0;
        step();
        wait_an(4'b1011);
        chk("wrap_dig2", seg, 7'b1000000);
        wait_an(4'b0111);
        chk("wrap_dig3", seg, 7'b1000000);
        pulse(8'h00);
        step();
        wait_an(4'b1011);
        chk("wrap_plus1_dig2", seg, 7'b1111001);

        // simultaneous rst+load, then two full frames of scan
        wait_an(4'b1101);
        rst = 1'b1;
        pulse(8'hFF);
        rst = 1'b0;
        chk("rl_an", an, 4'hF);
        act = '{0, 0, 0, 0};
        for (int i = 0; i < 4 * DIV * 2; i++) begin
            step();
            for (int k = 0; k < 4; k++) if (!an[k]) act[k]++;
            if (i < BL) chk("rl_blank", an, 4'hF);
            if (i == BL) begin
                chk("rl_restart_an", an, 4'b1110);
                chk("rl_val0", seg, 7'b1000000);
            end
            if (i == 2 * DIV + BL) chk("rl_cnt0", seg, 7'b1000000);
        end
        for (int k = 0; k < 4; k++) chk("slot_len", act[k], 2 * (DIV - BL));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/result_display_driver.md
# result_display_driver

Output-side counterpart to the switch/button capture pipeline: it takes the registered 8-bit `result` byte plus a one-cycle load strobe and presents it on a 4-digit multiplexed common-anode 7-segment display. Digits 1:0 show the latest result in hex. Digits 3:2 show a wrap-around count of loads. The block sits between the capture pipeline and the board display pins.

## Interface
- `REFRESH_DIV`, 100_000: clock cycles per digit slot; must be ≥ 4.
- `BLANK_CYCLES`, 1_000: cycles at the start of each slot with all anodes off (only with the macro); must be < `REFRESH_DIV`.
- `clk`  input  1  system clock.
- `rst`  input  1  synchronous, active-high reset.
- `result_in`  input  8  byte to display.
- `load`  input  1  one-cycle strobe; capture `result_in` on this edge.
- `seg`  output  7  segments {g,f,e,d,c,b,a}; active-low.
- `dp`  output  1  decimal point; active-low.
- `an`  output  4  digit anodes; active-low; `an[i]` selects digit i.

## Operation
- Holding registers:
  - `val[7:0]` takes `result_in` on every `load`=1 edge.
  - `cnt_ld[7:0]` increments by 1 mod 256 on every `load`=1 edge, so 255→0.
  - Back-to-back loads are each captured and counted.
- Scan state:
  - `tick` counts 0..`REFRESH_DIV`-1.
  - When `tick`=`REFRESH_DIV`-1, `tick` returns to 0 and `dig` advances 0→1→2→3→0.
- Digit sources:
  - dig0 = `val[3:0]`.
  - dig1 = `val[7:4]`.
  - dig2 = `cnt_ld[3:0]`.
  - dig3 = `cnt_ld[7:4]`.
- Hex encoding (active-low gfedcba):
  - 0=1000000, 1=1111001, 2=0100100, 3=0110000
  - 4=0011001, 5=0010010, 6=0000010, 7=1111000
  - 8=0000000, 9=0010000, A=0001000, b=0000011
  - C=1000110, d=0100001, E=0000110, F=0001110
- `dp`=0 only while digit 2 is driven, to separate the result pair from the count pair; otherwise `dp`=1.
- Only one anode may be low in any cycle. `an`=1111 is legal.
- Reset:
  - Clears `val`, `cnt_ld`, `tick` and `dig` to 0.
  - Drives `an`=1111, `seg`=1111111, `dp`=1.
  - `rst` takes priority over a simultaneous `load`; the load is discarded and not counted.
  - Reset mid-slot restarts the scan at digit 0 with `tick`=0.

## Timing
- `an`, `seg` and `dp` are registered. In each cycle they reflect the `tick`, `dig`, `val` and `cnt_ld` state of the previous cycle.
- First cycle after `rst` falls: the state is `tick`=0, `dig`=0, and the outputs still hold their reset values.
- Next cycle: digit 0 is driven, or blanked if the macro is on.
- Load latency: `load` on edge N updates `val`/`cnt_ld` at N. If the affected digit is active, `seg` shows the new value from edge N+1.
- Each digit is active for exactly `REFRESH_DIV` cycles per frame. One frame is 4×`REFRESH_DIV` cycles.
- Digit changes take effect exactly at slot boundaries; there are no partial-slot glitches.

## Configuration
- `GHOST_BLANK_EN` defined: while `tick` < `BLANK_CYCLES`, the registered outputs are `an`=1111, `seg`=1111111, `dp`=1. The digit is driven for the remaining `REFRESH_DIV`-`BLANK_CYCLES` cycles of the slot.
- `GHOST_BLANK_EN` undefined: the digit is driven for the full slot, and `BLANK_CYCLES` is ignored.

## Test plan
Use `REFRESH_DIV`=8 and `BLANK_CYCLES`=2 for all scenarios.
- Reset: assert `rst` for 3 cycles, then release.
  - Outputs stay at reset values through the first post-reset cycle.
  - Next cycle: `an`=1110 and `seg`=1000000 (macro off), or `an`=1111 for 2 cycles (macro on).
- Load 0xA5 once, then run one frame.
  - dig0 shows `seg`=0010010 ("5"); dig1 shows 0001000 ("A").
  - dig2 shows 1111001 ("1") with `dp`=0; dig3 shows 1000000 ("0").
- Load latency: pulse `load` with 0x3F while digit 0 is active.
  - `seg` changes to 0001110 ("F") on the next edge.
- Count wrap: issue 256 consecutive `load` pulses.
  - dig2 and dig3 both show "0".
  - One further pulse shows dig2="1".
- Simultaneous `rst`+`load` with 0xFF:
  - `val` and `cnt_ld` remain 0.
  - Scan restarts at `an`=1110.
- Scan check over 2 frames:
  - Exactly 0 or 1 bit of `an` is low in every cycle.
  - Each digit is active 8 cycles per slot (macro off) or 6 cycles per slot (macro on).
